// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads 16-bit big-endian instructions as two byte
// reads from a byte-wide memory and queues them for the decoder. A valid/ready
// handshake pops the head entry. Load_PC redirects fetch and flushes the queue.
module instruction_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        i_Clock,
    input  logic        i_Reset,      // active-low
    output logic [15:0] o_Mem_Addr,
    output logic        o_Mem_CS,     // active-low
    output logic        o_Mem_WR,
    input  logic [7:0]  i_Mem_Data,
    input  logic        i_Halt,
    input  logic        i_Load_PC,
    input  logic [15:0] i_New_PC,
    output logic        o_IR_Valid,
    output logic [15:0] o_IR_Out,
    output logic [15:0] o_IR_PC,
    input  logic        i_IR_Ready,
    output logic [15:0] o_PC_Out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        F_HI = 1'b0,
        F_LO = 1'b1
    } state_t;

    state_t             r_state;
    logic [15:0]        r_pc;
    logic [7:0]         r_hi;
    logic [15:0]        r_hi_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    // Each entry: {instruction word, address of its high byte}
    logic [31:0]        r_buf [DEPTH];

    state_t             w_state_next;
    logic [15:0]        w_pc_next;
    logic [7:0]         w_hi_next;
    logic [15:0]        w_hi_pc_next;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_fetch_hi;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    assign w_valid    = (r_count != '0);
    assign o_IR_Valid = w_valid;
    // Head is masked to zero when empty so no stale word is ever presented
    assign o_IR_Out   = w_valid ? r_buf[r_rd_ptr][31:16] : 16'h0;
    assign o_IR_PC    = w_valid ? r_buf[r_rd_ptr][15:0]  : 16'h0;
    assign o_Mem_Addr = r_pc;
    assign o_PC_Out   = r_pc;
    assign o_Mem_WR   = 1'b0;

    // Next-state, PC, queue pointer and chip-select decode
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_hi_next     = r_hi;
        w_hi_pc_next  = r_hi_pc;
        w_rd_ptr_next = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        w_count_next  = r_count;
        w_push        = 1'b0;
        w_pop         = w_valid && i_IR_Ready;
        // A slot is reserved when the high byte is fetched, so the low-byte
        // push can never find the queue full.
        w_fetch_hi    = (r_state == F_HI) && (r_count < CNT_W'(DEPTH)) && !i_Halt;
        o_Mem_CS      = 1'b1;

        if (i_Reset && (w_fetch_hi || (r_state == F_LO))) begin
            o_Mem_CS = 1'b0;
        end

        if (i_Load_PC) begin
            // Redirect wins: in-flight push and concurrent pop are dropped
            w_pc_next     = i_New_PC;
            w_state_next  = F_HI;
            w_rd_ptr_next = '0;
            w_wr_ptr_next = '0;
            w_count_next  = '0;
            w_pop         = 1'b0;
        end else begin
            case (r_state)
                F_HI: begin
                    if (w_fetch_hi) begin
                        w_hi_next    = i_Mem_Data;
                        w_hi_pc_next = r_pc;
                        w_pc_next    = r_pc + 16'd1;
                        w_state_next = F_LO;
                    end
                end
                F_LO: begin
                    w_push       = 1'b1;
                    w_pc_next    = r_pc + 16'd1;
                    w_state_next = F_HI;
                end
                default: w_state_next = F_HI;
            endcase
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state  <= F_HI;
            r_pc     <= RESET_PC;
            r_hi     <= 8'h0;
            r_hi_pc  <= 16'h0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_hi     <= w_hi_next;
            r_hi_pc  <= w_hi_pc_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Queue storage; contents need no reset because the head is masked when empty
    always_ff @(posedge i_Clock) begin
        if (w_push && i_Reset) begin
            r_buf[r_wr_ptr] <= {r_hi, i_Mem_Data, r_hi_pc};
        end
    end

endmodule
